// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce,
// sticky edge capture (W1C) and a maskable level interrupt.
module pio_input_edge_irq #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] irqmask_next;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_bits;

    assign unused_bits = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= '0;
                end else begin
                    deb <= sync2;
                end
            end
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt [WIDTH];

            // A bit only follows sync2 after D consecutive mismatching cycles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    deb <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] == deb[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            deb[i] <= sync2[i];
                            cnt[i] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        ev = deb ^ deb_d;
        if (EDGE_TYPE == 0) begin
            ev = deb & ~deb_d;
        end else if (EDGE_TYPE == 1) begin
            ev = ~deb & deb_d;
        end
    end

    assign wr_en = chipselect & ~write_n;
    assign clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A fresh edge outranks a simultaneous clear of the same bit.
    assign edgecap_next = (edgecap & ~clr) | ev;
    assign irqmask_next = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0]
                                                      : irqmask;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = deb;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d    <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            deb_d    <= deb;
            edgecap  <= edgecap_next;
            irqmask  <= irqmask_next;
            irq      <= |(edgecap_next & irqmask_next);
            readdata <= rd_mux;
        end
    end

endmodule
